serdes_var: RTL and testbench



---
 rtl/serdes_var.sv | 123 ++++++++++++
 tb/tb_serdes_var.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serdes_var.sv
// serdes_var
// Moves a runtime-selected number of W-bit words between a stream port and an
// N-word parallel buffer owned by the caller. The block can serialise,
// deserialise, or do both in the same step. The buffer is rotated one word
// toward word 0 on every transfer step. With ALIGN=1, a partial transfer is
// followed by pure rotations. This leaves the transferred words at positions
// 0..len-1.
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   cmd_startSer/Des         operation request, accepted only while idle
//   cmd_len                  words to move; 0 or >N means N
//   cmd_canReceive           idle, so a command would be accepted
//   cmd_done                 one-cycle pulse in the final cycle of an operation
//   buffer_read/write        owner's buffer in / next buffer value out
//   des, des_isReady,        inbound stream
//   des_canReceive, des_isLast
//   ser, ser_isReady,        outbound stream (ser is always word 0)
//   ser_canReceive, ser_isLast
module serdes_var #(
    parameter int W     = 64,
    parameter int N     = 4,
    parameter int ALIGN = 1,
    localparam int LW   = $clog2(N + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cmd_startSer,
    input  logic           cmd_startDes,
    input  logic [LW-1:0]  cmd_len,
    output logic           cmd_canReceive,
    output logic           cmd_done,
    input  logic [W*N-1:0] buffer_read,
    output logic [W*N-1:0] buffer_write,
    input  logic [W-1:0]   des,
    input  logic           des_isReady,
    output logic           des_canReceive,
    output logic           des_isLast,
    output logic [W-1:0]   ser,
    output logic           ser_isReady,
    input  logic           ser_canReceive,
    output logic           ser_isLast
);

    typedef enum logic [1:0] {IDLE, XFER, ALIGNING} state_t;

    localparam logic [LW-1:0] N_LW = LW'(N);
    localparam logic [LW-1:0] ONE  = LW'(1);

    state_t        state, state_next;
    logic          is_ser, is_des;
    logic [LW-1:0] rem, alg;

    logic          acc, step, last, in_xfer, in_align;
    logic [LW-1:0] len;
    logic [W-1:0]  word0, rot_in;
    logic [W*N-1:0] rotated;

    assign in_xfer  = (state == XFER);
    assign in_align = (state == ALIGNING);
    assign acc      = (state == IDLE) & (cmd_startSer | cmd_startDes);

    // A length of 0 selects the full buffer. Lengths above N saturate.
    assign len = ((cmd_len == '0) || (cmd_len > N_LW)) ? N_LW : cmd_len;

    assign word0 = buffer_read[W-1:0];
    assign ser   = word0;

    assign step = in_xfer & (~is_des | des_isReady) & (~is_ser | ser_canReceive);
    assign last = step & (rem == ONE);

    assign ser_isReady    = in_xfer & is_ser & (~is_des | des_isReady);
    assign des_canReceive = in_xfer & is_des & (~is_ser | ser_canReceive);
    assign ser_isLast     = last;
    assign des_isLast     = last;
    assign cmd_canReceive = (state == IDLE);
    assign cmd_done       = (last & (alg == '0)) | (in_align & (alg == ONE));

    // The word entering at the top comes from the inbound stream only during a
    // deserialising step. Otherwise word 0 wraps around.
    assign rot_in = (in_xfer && is_des) ? des : word0;

    // Rotate toward word 0. Written per word so that N=1 needs no special case.
    generate
        for (genvar gi = 0; gi < N - 1; gi++) begin : g_rot
            assign rotated[W*gi +: W] = buffer_read[W*(gi+1) +: W];
        end
    endgenerate
    assign rotated[W*(N-1) +: W] = rot_in;

    assign buffer_write = (step | in_align) ? rotated : buffer_read;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (acc) state_next = XFER;
            XFER:     if (last) state_next = (alg == '0) ? IDLE : ALIGNING;
            ALIGNING: if (alg == ONE) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            is_ser <= 1'b0;
            is_des <= 1'b0;
            rem    <= '0;
            alg    <= '0;
        end else begin
            state <= state_next;
            if (acc) begin
                is_ser <= cmd_startSer;
                is_des <= cmd_startDes;
                rem    <= len;
                alg    <= (ALIGN != 0) ? (N_LW - len) : '0;
            end
            if (step) rem <= rem - ONE;
            if (in_align) alg <= alg - ONE;
        end
    end

endmodule

// File: tb/tb_serdes_var.sv
// Directed bench for serdes_var (N=4, W=64). Two instances share the stimulus.
// One instance has ALIGN=1 and the other has ALIGN=0. Each owns a buffer
// register that loads buffer_write every cycle, or a preset value when load
// is high.
module tb_serdes_var;
    localparam int W  = 64;
    localparam int N  = 4;
    localparam int LW = 3;
    localparam int BW = W * N;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          cmd_startSer, cmd_startDes;
    logic [LW-1:0] cmd_len;
    logic [W-1:0]  des;
    logic          des_isReady, ser_canReceive;

    logic          cr, done, des_cr, des_last, ser_rdy, ser_last;
    logic [W-1:0]  ser;
    logic [BW-1:0] bw, bufr;
    logic          cr0, done0, des_cr0, des_last0, ser_rdy0, ser_last0;
    logic [W-1:0]  ser0;
    logic [BW-1:0] bw0, bufr0;

    logic          load;
    logic [BW-1:0] load_val;

    int total = 0;
    int passed = 0;

    localparam logic [W-1:0] A = 64'hAAAA_0000_0000_0001;
    localparam logic [W-1:0] B = 64'hBBBB_0000_0000_0002;
    localparam logic [W-1:0] C = 64'hCCCC_0000_0000_0003;
    localparam logic [W-1:0] D = 64'hDDDD_0000_0000_0004;
    localparam logic [W-1:0] X = 64'h1111_2222_3333_4444;
    localparam logic [W-1:0] Y = 64'h5555_6666_7777_8888;
    localparam logic [W-1:0] Z = 64'h9999_AAAA_BBBB_CCCC;

    serdes_var #(.W(W), .N(N), .ALIGN(1)) dut (
        .clk(clk), .rst(rst),
        .cmd_startSer(cmd_startSer), .cmd_startDes(cmd_startDes), .cmd_len(cmd_len),
        .cmd_canReceive(cr), .cmd_done(done),
        .buffer_read(bufr), .buffer_write(bw),
        .des(des), .des_isReady(des_isReady), .des_canReceive(des_cr), .des_isLast(des_last),
        .ser(ser), .ser_isReady(ser_rdy), .ser_canReceive(ser_canReceive), .ser_isLast(ser_last)
    );

    serdes_var #(.W(W), .N(N), .ALIGN(0)) dut0 (
        .clk(clk), .rst(rst),
        .cmd_startSer(cmd_startSer), .cmd_startDes(cmd_startDes), .cmd_len(cmd_len),
        .cmd_canReceive(cr0), .cmd_done(done0),
        .buffer_read(bufr0), .buffer_write(bw0),
        .des(des), .des_isReady(des_isReady), .des_canReceive(des_cr0), .des_isLast(des_last0),
        .ser(ser0), .ser_isReady(ser_rdy0), .ser_canReceive(ser_canReceive), .ser_isLast(ser_last0)
    );

    always @(posedge clk) begin
        bufr  <= load ? load_val : bw;
        bufr0 <= load ? load_val : bw0;
    end

    function automatic logic [BW-1:0] pack(input logic [W-1:0] w0, w1, w2, w3);
        return {w3, w2, w1, w0};
    endfunction

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_buf(input logic [BW-1:0] v);
        load_val = v;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // Serialise run on the full buffer. The done pulse must land at t+4
    // because both len=0 and len=7 mean 4. An optional busy request is
    // poked mid-transfer.
    task automatic ser_full(input logic [LW-1:0] l, input bit poke);
        logic [W-1:0] w [4];
        w[0] = A; w[1] = B; w[2] = C; w[3] = D;
        load_buf(pack(A, B, C, D));
        cmd_startSer = 1'b1; cmd_len = l; ser_canReceive = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            cmd_startSer = (poke && k == 2);
            cmd_startDes = (poke && k == 2);
            #1;
            $display("len=%0d cycle t+%0d ser=%h done=%0b", l, k, ser, done);
            chk($sformatf("len%0d_ser_k%0d", l, k), ser, w[k-1]);
            chk($sformatf("len%0d_done_k%0d", l, k), done, (k == 4));
            chk($sformatf("len%0d_last_k%0d", l, k), ser_last, (k == 4));
            if (poke && k == 2) begin
                chk("busy_cr", cr, 0);
                chk("busy_des_cr", des_cr, 0);
            end
        end
        tick(); #1;
        chk($sformatf("len%0d_buf", l), bufr, pack(A, B, C, D));
        chk($sformatf("len%0d_idle", l), cr, 1);
    endtask

    initial begin
        rst = 1'b0;
        cmd_startSer = 0; cmd_startDes = 0; cmd_len = '0;
        des = '0; des_isReady = 0; ser_canReceive = 0;
        load = 1'b1; load_val = pack(A, B, C, D);
        tick(); tick();
        load = 1'b0;
        #1;
        // Reset state
        chk("rst_cr", cr, 1);
        chk("rst_done", done, 0);
        chk("rst_ser_rdy", ser_rdy, 0);
        chk("rst_des_cr", des_cr, 0);
        chk("rst_last", {ser_last, des_last}, 0);
        chk("rst_bw", bw, pack(A, B, C, D));
        $display("reset state checked");
        rst = 1'b1;
        tick();

        // Serialise, len=4
        ser_full(3'd4, 1'b0);

        // Deserialise len=2. Two rotate cycles follow, and done comes at t+4.
        load_buf(pack(A, B, C, D));
        cmd_startDes = 1'b1; cmd_len = 3'd2; des_isReady = 1'b1; des = X;
        #1;
        tick(); cmd_startDes = 1'b0; des = X; #1;
        $display("des t+1 des_cr=%0b", des_cr);
        chk("des_t1_cr", des_cr, 1);
        chk("des_t1_last", des_last, 0);
        chk("des_t1_busy", cr, 0);
        tick(); des = Y; #1;
        $display("des t+2 last=%0b done0=%0b", des_last, done0);
        chk("des_t2_last", des_last, 1);
        chk("des_t2_done", done, 0);
        chk("des_t2_done_a0", done0, 1);
        tick(); des_isReady = 1'b0; #1;
        chk("des_t3_done", done, 0);
        chk("des_t3_des_cr", des_cr, 0);
        tick(); #1;
        $display("des t+4 done=%0b", done);
        chk("des_t4_done", done, 1);
        chk("des_t4_busy", cr, 0);
        tick(); #1;
        $display("des t+5 buf=%h", bufr);
        chk("des_t5_idle", cr, 1);
        chk("des_buf", bufr, pack(X, Y, C, D));
        chk("des_buf_a0", bufr0, pack(C, D, X, Y));

        // Ser+Des len=3, with a 2-cycle stall on ser_canReceive
        load_buf(pack(A, B, C, D));
        cmd_startSer = 1'b1; cmd_startDes = 1'b1; cmd_len = 3'd3;
        ser_canReceive = 1'b1; des_isReady = 1'b1; des = X;
        #1;
        tick(); cmd_startSer = 0; cmd_startDes = 0; #1;
        $display("sd t+1 ser=%h", ser);
        chk("sd_t1_ser", ser, A);
        chk("sd_t1_rdy", {ser_rdy, des_cr}, 2'b11);
        tick(); ser_canReceive = 1'b0; #1;
        chk("sd_t2_des_cr", des_cr, 0);
        chk("sd_t2_ser_rdy", ser_rdy, 1);
        chk("sd_t2_hold", bw, pack(B, C, D, X));
        tick(); #1;
        chk("sd_t3_hold", bw, pack(B, C, D, X));
        tick(); ser_canReceive = 1'b1; des = Y; #1;
        $display("sd t+4 ser=%h", ser);
        chk("sd_t4_ser", ser, B);
        chk("sd_t4_last", ser_last, 0);
        tick(); des = Z; #1;
        $display("sd t+5 ser=%h last=%0b", ser, ser_last);
        chk("sd_t5_ser", ser, C);
        chk("sd_t5_last", {ser_last, des_last}, 2'b11);
        chk("sd_t5_done", done, 0);
        tick(); des_isReady = 1'b0; #1;
        chk("sd_t6_done", done, 1);
        tick(); #1;
        $display("sd t+7 buf=%h", bufr);
        chk("sd_buf", bufr, pack(X, Y, Z, D));
        chk("sd_idle", cr, 1);

        // len=0 and len=7 both mean N. A busy request is ignored.
        ser_full(3'd0, 1'b0);
        ser_full(3'd7, 1'b1);

        // ALIGN=0, Ser len=1. This leaves the buffer rotated.
        load_buf(pack(A, B, C, D));
        cmd_startSer = 1'b1; cmd_len = 3'd1; ser_canReceive = 1'b1;
        #1;
        tick(); cmd_startSer = 1'b0; #1;
        $display("a0 t+1 done0=%0b done=%0b", done0, done);
        chk("a0_t1_done0", done0, 1);
        chk("a0_t1_last0", ser_last0, 1);
        chk("a0_t1_done", done, 0);
        tick(); #1;
        chk("a0_buf", bufr0, pack(B, C, D, A));
        chk("a0_idle", cr0, 1);
        tick(); tick(); #1;
        chk("a1_t4_done", done, 1);
        tick(); #1;
        chk("a1_buf", bufr, pack(A, B, C, D));

        // Reset during XFER word 2
        load_buf(pack(A, B, C, D));
        cmd_startSer = 1'b1; cmd_len = 3'd4; ser_canReceive = 1'b1;
        #1;
        tick(); cmd_startSer = 1'b0; #1;
        tick(); rst = 1'b0; #1;
        $display("mid-reset cr=%0b ser_rdy=%0b", cr, ser_rdy);
        chk("mrst_cr", cr, 1);
        chk("mrst_ser_rdy", ser_rdy, 0);
        chk("mrst_des_cr", des_cr, 0);
        chk("mrst_done", done, 0);
        chk("mrst_last", {ser_last, des_last}, 0);
        chk("mrst_bw", bw, pack(B, C, D, A));
        tick(); rst = 1'b1;
        cmd_startSer = 1'b1; cmd_len = 3'd1;
        #1;
        chk("post_rst_cr", cr, 1);
        tick(); cmd_startSer = 1'b0; #1;
        $display("post-reset accept ser=%h", ser);
        chk("post_rst_busy", cr, 0);
        chk("post_rst_ser", ser, B);
        chk("post_rst_last", ser_last, 1);
        tick(); tick(); tick(); #1;
        chk("post_rst_done", done, 1);
        tick(); #1;
        chk("post_rst_buf", bufr, pack(B, C, D, A));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
